fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the instruction-fetch stage. It owns the program counter and drives a single-outstanding request/acknowledge handshake to instruction memory. Fetched instructions are delivered to decode through a valid/stall handshake with a one-entry skid buffer. Branch and jump redirects from execute kill in-flight and buffered instructions.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, value of `inst` at reset

- cpu_clk  in  1  clock, rising edge
- cpu_rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, combinational from state
- imem_addr  out  32  fetch address; equals `pc`
- imem_ack  in  1  memory completes the request this cycle; ignored when `imem_req`=0
- imem_rdata  in  32  instruction word, valid with `imem_ack`
- redirect  in  1  execute resolved a taken branch or jump
- redirect_pc  in  32  target address, valid with `redirect`
- stall  in  1  decode cannot accept this cycle
- inst_valid  out  1  `inst`/`inst_pc`/`inst_pc4` hold a live instruction
- inst  out  32  instruction word, registered
- inst_pc  out  32  address of `inst`, registered
- inst_pc4  out  32  `inst_pc`+4, registered
- pc  out  32  current fetch PC, registered

## Operation
- Accept: decode takes the output when `inst_valid`=1 and `stall`=0.
- Slot free: `inst_valid`=0, or an accept happens this cycle.
- States and `imem_req` value:
  - IDLE (reset state): `imem_req`=0.
  - FETCH: `imem_req`=1.
  - DRAIN: `imem_req`=0; holds one instruction in the skid register.
  - FLUSH: `imem_req`=1 to the stale address; waits to discard the response.
- `imem_addr` never changes while `imem_req`=1 and no ack has arrived.
- `redirect` has priority over every other event.
- IDLE: always go to FETCH next edge. If `redirect` is high, load `pc`<=`redirect_pc`.
- FETCH, ack with no redirect:
  - Always: `pc`<=`pc`+4.
  - If slot free: load the output registers from `imem_rdata`/`pc`, set `inst_valid`=1, stay in FETCH.
  - Else: load skid {`imem_rdata`, `pc`} and go to DRAIN.
- FETCH, redirect with ack: discard the data, `pc`<=`redirect_pc`, stay in FETCH.
- FETCH, redirect with no ack: latch `redirect_pc` into the pending register `rpc` and go to FLUSH.
- FETCH, no ack and an accept: `inst_valid`<=0.
- FLUSH:
  - A new `redirect` overwrites `rpc`.
  - On ack: discard the data, `pc`<=`rpc` (or `redirect_pc` if `redirect` is high the same cycle), go to FETCH.
- DRAIN:
  - On accept: move skid to output with `inst_valid`=1, go to FETCH.
  - On `redirect`: drop skid, `pc`<=`redirect_pc`, go to FETCH.
- Any `redirect`: `inst_valid`<=0 at the same edge, in every state. No instruction from before the redirect ever reaches decode after the redirect cycle.
- Arithmetic: all PC math is 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. No alignment checks.

## Timing
- Reset values:
  - state=IDLE
  - `pc`=`imem_addr`=RESET_PC
  - `imem_req`=0
  - `inst_valid`=0
  - `inst`=NOP_INST
  - `inst_pc`=0
  - `inst_pc4`=4
  - skid and `rpc` = 0, skid empty
- Reset is asynchronous. Asserting it mid-request abandons the request; the memory must tolerate `imem_req` dropping without an ack.
- First request: `imem_req`=1 in the first cycle after the first rising edge following reset release.
- Latency: an ack at edge N makes `inst_valid`=1 in cycle N+1 (slot free).
- Throughput: a zero-wait memory (ack in the same cycle as req) with no stall gives one instruction per cycle.
- A redirect at edge N gives `imem_addr`=`redirect_pc` in cycle N+1 (FETCH/IDLE/DRAIN). In FLUSH, the new address appears one cycle after the stale ack.
- Stall: at most one instruction is held beyond the output register. No request is issued while the skid register is full.

## Test plan
- Reset release, zero-wait memory returning `addr`^32'hA5A5_0000, `stall`=0 → `imem_addr` steps 0,4,8,…; `inst_valid`=1 from cycle 2; `inst_pc4`=`inst_pc`+4 every cycle.
- Memory acks 3 cycles after req → `imem_addr` holds stable 3 cycles per fetch; one instruction per 3 cycles; `pc` advances only on ack.
- `stall`=1 for 4 cycles while fetching at 0x10 → output holds 0x10, skid holds 0x14, `imem_req`=0. Releasing stall delivers 0x10, 0x14, 0x18 in order with none lost or duplicated.
- `redirect`=1, `redirect_pc`=0x200 with no ack pending at 0x20 (ack 2 cycles later) → FLUSH; the 0x20 data is discarded; next `imem_addr`=0x200; first valid `inst_pc`=0x200.
- Redirect during DRAIN with `stall`=1 → `inst_valid`=0 next cycle, skid dropped; fetch resumes at the target.
- `pc`=32'hFFFF_FFFC with ack → next `imem_addr`=0; cpu_rst pulse mid-request → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs a single-outstanding imem handshake
// and feeds decode through an output register backed by a one-entry skid buffer.
//
// state | meaning
// IDLE  | after reset, no request yet
// FETCH | request outstanding at pc
// DRAIN | output and skid both full, no request
// FLUSH | redirect seen before ack; stale response still owed, target kept in rpc
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

    state_t      state, state_d;
    logic [31:0] pc_d, inst_d, inst_pc_d, inst_pc4_d;
    logic [31:0] skid_inst, skid_inst_d, skid_pc, skid_pc_d, rpc, rpc_d;
    logic        inst_valid_d;
    logic        accept, slot_free, ack;

    assign imem_req  = (state == FETCH) || (state == FLUSH);
    assign imem_addr = pc;
    assign accept    = inst_valid && !stall;
    assign slot_free = !inst_valid || accept;
    assign ack       = imem_req && imem_ack;

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        inst_valid_d = inst_valid;
        inst_d       = inst;
        inst_pc_d    = inst_pc;
        inst_pc4_d   = inst_pc4;
        skid_inst_d  = skid_inst;
        skid_pc_d    = skid_pc;
        rpc_d        = rpc;

        // Redirect kills the output; an accept empties it unless refilled below.
        if (redirect || accept)
            inst_valid_d = 1'b0;

        case (state)
            IDLE: begin
                state_d = FETCH;
                if (redirect)
                    pc_d = redirect_pc;
            end
            FETCH: begin
                if (redirect) begin
                    if (ack) begin
                        pc_d = redirect_pc;
                    end else begin
                        rpc_d   = redirect_pc;
                        state_d = FLUSH;
                    end
                end else if (ack) begin
                    pc_d = pc + 32'd4;
                    if (slot_free) begin
                        inst_valid_d = 1'b1;
                        inst_d       = imem_rdata;
                        inst_pc_d    = pc;
                        inst_pc4_d   = pc + 32'd4;
                    end else begin
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (accept) begin
                    inst_valid_d = 1'b1;
                    inst_d       = skid_inst;
                    inst_pc_d    = skid_pc;
                    inst_pc4_d   = skid_pc + 32'd4;
                    state_d      = FETCH;
                end
            end
            FLUSH: begin
                if (redirect)
                    rpc_d = redirect_pc;
                if (ack) begin
                    pc_d    = redirect ? redirect_pc : rpc;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= 32'h0000_0000;
            inst_pc4   <= 32'h0000_0004;
            skid_inst  <= 32'h0000_0000;
            skid_pc    <= 32'h0000_0000;
            rpc        <= 32'h0000_0000;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            inst_valid <= inst_valid_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
            inst_pc4   <= inst_pc4_d;
            skid_inst  <= skid_inst_d;
            skid_pc    <= skid_pc_d;
            rpc        <= rpc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences, then random traffic
// checked against a queue-based model of the output/skid storage.
module tb_fetch_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst, inst_pc, inst_pc4, pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_pc4(inst_pc4), .pc(pc)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Model: instructions held for decode (output first, then skid), fetch address,
    // and whether the next ack belongs to a request already killed by a redirect.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        held[$];
    logic        started, stale;
    logic [31:0] mpc, pend;

    typedef struct {
        logic        s, a, r;
        logic [31:0] rp, rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst, e_ipc, e_ipc4;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        held.delete();
        started = 1'b0;
        stale   = 1'b0;
        mpc     = 32'h0;
        pend    = 32'h0;
    endtask

    task automatic model_edge();
        logic req_v, acc;
        req_v = started && (held.size() < 2);
        acc   = (held.size() > 0) && !stall;
        if (!started) begin
            started = 1'b1;
            if (redirect) mpc = redirect_pc;
        end else if (redirect) begin
            held.delete();
            if (req_v && imem_ack) begin
                mpc   = redirect_pc;
                stale = 1'b0;
            end else if (req_v) begin
                stale = 1'b1;
                pend  = redirect_pc;
            end else begin
                mpc = redirect_pc;
            end
        end else begin
            if (acc) void'(held.pop_front());
            if (req_v && imem_ack) begin
                if (stale) begin
                    mpc   = pend;
                    stale = 1'b0;
                end else begin
                    held.push_back('{imem_rdata, mpc});
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    task automatic model_check();
        logic mreq;
        mreq = started && (held.size() < 2);
        chk("m_req", 32'(imem_req), 32'(mreq));
        chk("m_addr", imem_addr, mpc);
        chk("m_pc", pc, mpc);
        chk("m_valid", 32'(inst_valid), 32'(held.size() > 0));
        if (held.size() > 0) begin
            chk("m_inst", inst, held[0].ins);
            chk("m_inst_pc", inst_pc, held[0].pc);
            chk("m_inst_pc4", inst_pc4, held[0].pc + 32'd4);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic r,
                        input logic [31:0] rp, input logic [31:0] rd);
        stall = s; imem_ack = a; redirect = r; redirect_pc = rp; imem_rdata = rd;
        @(posedge cpu_clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_inst"}, inst, 32'h0000_0013);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_inst_pc4"}, inst_pc4, 32'h4);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,                 1'b1, 32'h0,          1'b0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hA5A5_0000,         1'b1, 32'h4,          1'b1, 32'hA5A5_0000, 32'h0, 32'h4};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hA5A5_0004,         1'b0, 32'h8,          1'b1, 32'hA5A5_0000, 32'h0, 32'h4};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF,         1'b0, 32'h8,          1'b1, 32'hA5A5_0000, 32'h0, 32'h4};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,                 1'b1, 32'h8,          1'b1, 32'hA5A5_0004, 32'h4, 32'h8};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,                 1'b1, 32'h8,          1'b0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h200, 32'h0,               1'b1, 32'h8,          1'b0, 32'h0, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h300, 32'h0,               1'b1, 32'h8,          1'b0, 32'h0, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'hBAD0_BAD0,         1'b1, 32'h300,        1'b0, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h1111_2222,         1'b1, 32'h304,        1'b1, 32'h1111_2222, 32'h300, 32'h304};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h3333_4444, 1'b1, 32'hFFFF_FFFC,  1'b0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_6666,         1'b1, 32'h0,          1'b1, 32'h5555_6666, 32'hFFFF_FFFC, 32'h0};

        cpu_rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        model_reset();
        #12;
        check_reset_values("rst");
        cpu_rst = 1'b0;

        // Directed table: zero-wait fetch, stall into skid, FLUSH with re-redirect, wrap.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].s, vecs[i].a, vecs[i].r, vecs[i].rp, vecs[i].rd);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
                chk($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
                chk($sformatf("v%0d_inst_pc4", i), inst_pc4, vecs[i].e_ipc4);
            end
        end

        // Redirect while DRAIN holds the skid: both entries dropped.
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h7777_0000);
        chk("drain_req", 32'(imem_req), 32'h0);
        chk("drain_addr", imem_addr, 32'h4);
        step(1'b1, 1'b0, 1'b1, 32'h400, 32'h0);
        chk("drain_redir_valid", 32'(inst_valid), 32'h0);
        chk("drain_redir_addr", imem_addr, 32'h400);
        chk("drain_redir_req", 32'(imem_req), 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h8888_0000);
        chk("drain_resume_valid", 32'(inst_valid), 32'h1);
        chk("drain_resume_pc", inst_pc, 32'h400);
        chk("drain_resume_inst", inst, 32'h8888_0000);

        // Asynchronous reset in the middle of an outstanding request.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        #3 cpu_rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        #2 cpu_rst = 1'b0;

        // Random traffic: zero-wait memory first, then a slow, irregular memory.
        for (int c = 0; c < 3000; c++) begin
            logic        s, a, r;
            logic [31:0] rp;
            s  = (c < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            a  = (c < 400) ? 1'b1 : ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 15) == 0);
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            step(s, a, r, rp, imem_addr ^ 32'hA5A5_0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
